// File: rtl/escalonador_pkg.sv
// Shared types and codes for the OLED frame scheduler.
package escalonador_pkg;

    localparam int unsigned FONTE_W  = 2;
    localparam int unsigned QUADRO_W = 8;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DISPARA = 2'd1,
        AGUARDA = 2'd2,
        MORTO   = 2'd3
    } estado_t;

    localparam logic [FONTE_W-1:0] FONTE_NENHUMA = 2'd0;
    localparam logic [FONTE_W-1:0] FONTE_ANIM    = 2'd1;
    localparam logic [FONTE_W-1:0] FONTE_EVENTO  = 2'd2;
    localparam logic [FONTE_W-1:0] FONTE_MORTE   = 2'd3;

    // Fixed priority: death screen, then button event, then animation.
    function automatic logic [FONTE_W-1:0] fonte_prioritaria(
        input logic morte,
        input logic evento,
        input logic anim
    );
        if (morte) begin
            return FONTE_MORTE;
        end else if (evento) begin
            return FONTE_EVENTO;
        end else if (anim) begin
            return FONTE_ANIM;
        end
        return FONTE_NENHUMA;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Free-running divider: one-cycle tick every DIV clock cycles.
module divisor_tick #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Count 0..DIV-1, flag the wrap cycle.
    always_comb begin
        tick_d = 1'b0;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/escalonador_quadros.sv
// Frame scheduler: arbitrates frame requests, strobes the display driver,
// watches for completion and selects the image source.
module escalonador_quadros
    import escalonador_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25_000_000,
    parameter int unsigned FPS         = 10,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_morte,
    input  logic       req_evento,
    input  logic       disp_busy,
    input  logic       disp_done,
    output logic       disp_start,
    output logic [1:0] fonte_sel,
    output logic [7:0] quadro_cnt,
    output logic       erro_timeout,
    output logic       ocupado
);

    localparam int unsigned TICK_DIV = CLK_HZ / FPS;
    localparam int unsigned WD_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic tick;

    estado_t             estado_q, estado_d;
    logic                pend_morte_q, pend_morte_d;
    logic                pend_evento_q, pend_evento_d;
    logic                pend_anim_q, pend_anim_d;
    logic [FONTE_W-1:0]  fonte_sel_q, fonte_sel_d;
    logic [QUADRO_W-1:0] quadro_cnt_q, quadro_cnt_d;
    logic                disp_start_q, disp_start_d;
    logic                erro_timeout_q, erro_timeout_d;
    logic                ocupado_q, ocupado_d;
    logic [WD_W-1:0]     wd_q, wd_d;

    logic                eff_morte, eff_evento, eff_anim;
    logic [FONTE_W-1:0]  fonte_grant;
    logic [WD_W-1:0]     wd_inc;

    divisor_tick #(
        .DIV (TICK_DIV)
    ) u_divisor_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A request arriving this cycle is visible to the grant in the same cycle.
    assign eff_morte   = pend_morte_q  | req_morte;
    assign eff_evento  = pend_evento_q | req_evento;
    assign eff_anim    = pend_anim_q   | tick;
    assign fonte_grant = fonte_prioritaria(eff_morte, eff_evento, eff_anim);
    assign wd_inc      = wd_q + WD_W'(1);

    // Next-state, pending-flag and output logic.
    always_comb begin
        estado_d       = estado_q;
        pend_morte_d   = eff_morte;
        pend_evento_d  = eff_evento;
        pend_anim_d    = eff_anim;
        fonte_sel_d    = fonte_sel_q;
        quadro_cnt_d   = quadro_cnt_q;
        disp_start_d   = 1'b0;
        erro_timeout_d = erro_timeout_q;
        wd_d           = wd_q;

        unique case (estado_q)
            OCIOSO: begin
                if (!disp_busy && (eff_morte || eff_evento || eff_anim)) begin
                    fonte_sel_d  = fonte_grant;
                    disp_start_d = 1'b1;
                    estado_d     = DISPARA;
                    // A same-cycle request only survives the clear if a frame was
                    // already pending; otherwise it is the one being granted.
                    if (fonte_grant == FONTE_EVENTO) begin
                        pend_evento_d = pend_evento_q & req_evento;
                    end
                    if (fonte_grant == FONTE_ANIM) begin
                        pend_anim_d = pend_anim_q & tick;
                    end
                end
            end
            DISPARA: begin
                wd_d     = '0;
                estado_d = AGUARDA;
            end
            AGUARDA: begin
                wd_d = wd_inc;
                if (disp_done) begin
                    if (fonte_sel_q == FONTE_ANIM) begin
                        quadro_cnt_d = quadro_cnt_q + QUADRO_W'(1);
                    end
                    estado_d = (fonte_sel_q == FONTE_MORTE) ? MORTO : OCIOSO;
                end else if (wd_inc == WD_W'(TIMEOUT_CYC - 1)) begin
                    erro_timeout_d = 1'b1;
                    estado_d       = OCIOSO;
                end
            end
            MORTO: begin
                estado_d = MORTO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        ocupado_d = (estado_d != OCIOSO);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q       <= OCIOSO;
            pend_morte_q   <= 1'b0;
            pend_evento_q  <= 1'b0;
            pend_anim_q    <= 1'b0;
            fonte_sel_q    <= FONTE_NENHUMA;
            quadro_cnt_q   <= '0;
            disp_start_q   <= 1'b0;
            erro_timeout_q <= 1'b0;
            ocupado_q      <= 1'b0;
            wd_q           <= '0;
        end else begin
            estado_q       <= estado_d;
            pend_morte_q   <= pend_morte_d;
            pend_evento_q  <= pend_evento_d;
            pend_anim_q    <= pend_anim_d;
            fonte_sel_q    <= fonte_sel_d;
            quadro_cnt_q   <= quadro_cnt_d;
            disp_start_q   <= disp_start_d;
            erro_timeout_q <= erro_timeout_d;
            ocupado_q      <= ocupado_d;
            wd_q           <= wd_d;
        end
    end

    assign disp_start   = disp_start_q;
    assign fonte_sel    = fonte_sel_q;
    assign quadro_cnt   = quadro_cnt_q;
    assign erro_timeout = erro_timeout_q;
    assign ocupado      = ocupado_q;

endmodule

// File: tb/tb_escalonador_quadros.sv
// Bench for the frame scheduler: flag-level reference model, scoreboard of
// in-flight frames, display driver model answering 20 cycles after start.
module tb_escalonador_quadros;

    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned FPS      = 10;
    localparam int          TICK     = 100;
    localparam int          TIMEOUT  = 50;
    localparam int          DONE_LAT = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_morte = 1'b0;
    logic       req_evento = 1'b0;
    logic       disp_busy = 1'b0;
    logic       disp_done = 1'b0;
    logic       disp_start;
    logic [1:0] fonte_sel;
    logic [7:0] quadro_cnt;
    logic       erro_timeout;
    logic       ocupado;

    escalonador_quadros #(
        .CLK_HZ      (CLK_HZ),
        .FPS         (FPS),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_morte    (req_morte),
        .req_evento   (req_evento),
        .disp_busy    (disp_busy),
        .disp_done    (disp_done),
        .disp_start   (disp_start),
        .fonte_sel    (fonte_sel),
        .quadro_cnt   (quadro_cnt),
        .erro_timeout (erro_timeout),
        .ocupado      (ocupado)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state (pending requests as a set of flags).
    int cyc = 0;
    bit m_morte, m_evento, m_anim;
    bit prev_pend_e, prev_req_e, prev_pend_a, prev_tick, prev_busy;
    int m_cnt;
    bit m_erro;
    int q_src[$];
    bit q_to[$];
    int age;
    int done_cd;
    bit withhold;
    int n_start;
    int n_src[4];
    int last_start_cyc;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive during cycle n (just after its opening edge).
    task automatic at_cycle(input int n);
        while (cyc < n - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_evento();
        req_evento = 1'b1;
        @(posedge clk);
        #1;
        req_evento = 1'b0;
    endtask

    // Display driver: disp_done DONE_LAT cycles after each non-withheld start.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            disp_done = 1'b0;
            done_cd   = 0;
        end else begin
            disp_done = (done_cd == 1);
            if (done_cd > 0) done_cd--;
        end
    end

    // Monitor + reference model: checks each grant and each completion.
    initial forever begin
        int exp_src;
        int src;
        bit tk;
        @(negedge clk);
        if (rst) begin
            cyc = 0;
            m_morte = 0; m_evento = 0; m_anim = 0;
            prev_pend_e = 0; prev_req_e = 0; prev_pend_a = 0; prev_tick = 0;
            prev_busy = 0; m_cnt = 0; m_erro = 0; age = 0; done_cd = 0;
            q_src.delete();
            q_to.delete();
            continue;
        end
        cyc++;

        // Completion or watchdog expiry of the in-flight frame.
        if (q_src.size() > 0) begin
            age++;
            if (q_to[0]) begin
                if (age == TIMEOUT - 1) chk("erro_before_timeout", int'(erro_timeout), int'(m_erro));
                if (age == TIMEOUT) begin
                    m_erro = 1;
                    chk("erro_at_timeout", int'(erro_timeout), 1);
                    void'(q_src.pop_front());
                    void'(q_to.pop_front());
                end
            end else if (disp_done) begin
                src = q_src.pop_front();
                void'(q_to.pop_front());
                chk("fonte_held_at_done", int'(fonte_sel), src);
                if (src == 1) m_cnt = (m_cnt + 1) % 256;
            end
        end

        // A start reflects a grant decided last cycle from the pending set.
        if (disp_start) begin
            n_start++;
            last_start_cyc = cyc;
            exp_src = m_morte ? 3 : (m_evento ? 2 : (m_anim ? 1 : 0));
            n_src[exp_src]++;
            chk("no_grant_while_busy", int'(prev_busy), 0);
            chk("fonte_sel_grant", int'(fonte_sel), exp_src);
            chk("quadro_cnt_at_start", int'(quadro_cnt), m_cnt);
            chk("erro_at_start", int'(erro_timeout), int'(m_erro));
            chk("ocupado_at_start", int'(ocupado), 1);
            if (exp_src == 2) m_evento = prev_pend_e & prev_req_e;
            if (exp_src == 1) m_anim = prev_pend_a & prev_tick;
            q_src.push_back(exp_src);
            q_to.push_back(withhold);
            age = 0;
            if (!withhold) done_cd = DONE_LAT;
            withhold = 0;
        end

        // Requests of this cycle join the pending set.
        tk = (cyc % TICK == 0);
        prev_pend_e = m_evento;
        prev_req_e  = req_evento;
        prev_pend_a = m_anim;
        prev_tick   = tk;
        m_evento |= req_evento;
        m_morte  |= req_morte;
        m_anim   |= tk;
        prev_busy = disp_busy;
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL sim_time_limit: got cycle %0d, expected finish", cyc);
        $fatal(1, "time limit");
    end

    // Directed scenarios with a randomized stretch.
    initial begin
        int n_ref, cnt_ref, ev_ref, anim_ref;

        #22;
        chk("reset_disp_start", int'(disp_start), 0);
        chk("reset_fonte_sel", int'(fonte_sel), 0);
        chk("reset_quadro_cnt", int'(quadro_cnt), 0);
        chk("reset_erro", int'(erro_timeout), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Free-running animation.
        at_cycle(1030);
        chk("anim_start_count", n_start, 10);
        chk("anim_frames", n_src[1], 10);
        chk("anim_quadro_cnt", int'(quadro_cnt), 10);
        chk("anim_no_erro", int'(erro_timeout), 0);

        // Event frame latency and coalescing.
        at_cycle(1040);
        pulse_evento();
        at_cycle(1043);
        chk("evento_latency", last_start_cyc, 1041);
        at_cycle(1045); pulse_evento();
        at_cycle(1050); pulse_evento();
        at_cycle(1055); pulse_evento();
        at_cycle(1095);
        chk("evento_coalesced", n_src[2], 2);
        chk("evento_cnt_unchanged", int'(quadro_cnt), 10);
        chk("evento_idle", int'(ocupado), 0);

        // Random events and driver backpressure.
        for (int c = 1100; c < 3000; c++) begin
            at_cycle(c);
            disp_busy  = ($urandom_range(0, 5) == 0);
            req_evento = ($urandom_range(0, 39) == 0);
        end
        at_cycle(3000);
        disp_busy  = 1'b0;
        req_evento = 1'b0;
        at_cycle(3090);
        chk("random_idle", int'(ocupado), 0);
        chk("random_cnt", int'(quadro_cnt), m_cnt);

        // Withheld done: watchdog expiry, frame dropped.
        n_ref   = n_start;
        cnt_ref = m_cnt;
        withhold = 1'b1;
        at_cycle(3250);
        chk("timeout_next_tick_served", n_start, n_ref + 2);
        chk("timeout_erro_sticky", int'(erro_timeout), 1);
        chk("timeout_frame_dropped", int'(quadro_cnt), (cnt_ref + 1) % 256);

        // Busy hold with several ticks: one coalesced frame afterwards.
        disp_busy = 1'b1;
        n_ref    = n_start;
        anim_ref = n_src[1];
        at_cycle(3550);
        chk("busy_no_start", n_start, n_ref);
        disp_busy = 1'b0;
        at_cycle(3595);
        chk("busy_one_frame", n_start, n_ref + 1);
        chk("busy_anim_frame", n_src[1], anim_ref + 1);

        // Asynchronous reset in the middle of a transfer.
        at_cycle(3607);
        chk("pre_reset_busy", int'(ocupado), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_disp_start", int'(disp_start), 0);
        chk("async_rst_fonte_sel", int'(fonte_sel), 0);
        chk("async_rst_ocupado", int'(ocupado), 0);
        chk("async_rst_erro", int'(erro_timeout), 0);
        chk("async_rst_quadro_cnt", int'(quadro_cnt), 0);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // 256 animation frames: counter wraps.
        at_cycle(25550);
        chk("quadro_cnt_255", int'(quadro_cnt), 255);
        at_cycle(25650);
        chk("quadro_cnt_wrap", int'(quadro_cnt), 0);
        chk("wrap_no_erro", int'(erro_timeout), 0);

        // Death, event and tick all pending together.
        disp_busy = 1'b1;
        ev_ref = n_src[2];
        at_cycle(25660);
        pulse_evento();
        at_cycle(25670);
        req_morte = 1'b1;
        at_cycle(25710);
        disp_busy = 1'b0;
        at_cycle(25712);
        chk("morte_first_grant", int'(fonte_sel), 3);
        chk("morte_over_evento", n_src[2], ev_ref);
        at_cycle(25740);
        chk("morto_ocupado", int'(ocupado), 1);
        n_ref = n_start;
        at_cycle(26240);
        chk("morto_no_start", n_start, n_ref);
        chk("morto_fonte_held", int'(fonte_sel), 3);
        chk("morto_still_busy", int'(ocupado), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
